// File: rtl/fetch_queue_if.sv
// Fetch-stage boundary: imem request/response, redirect input and the decode-side dequeue port.
// The dequeue port uses valid/ready: an entry transfers on a rising edge where deq_valid and deq_ready are both high and redirect is low.
interface fetch_queue_if #(
    parameter int DEPTH = 4
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             imemREN;
    logic [31:0]      imemaddr;
    logic             ihit;
    logic [31:0]      imemload;
    logic             redirect;
    logic [31:0]      redirect_addr;
    logic             deq_ready;
    logic             deq_valid;
    logic [31:0]      deq_instr;
    logic [31:0]      deq_pc;
    logic [CNT_W-1:0] count;
    logic             fetch_stopped;

    modport master (
        output imemREN, imemaddr, deq_valid, deq_instr, deq_pc, count, fetch_stopped,
        input  ihit, imemload, redirect, redirect_addr, deq_ready
    );

    modport slave (
        input  imemREN, imemaddr, deq_valid, deq_instr, deq_pc, count, fetch_stopped,
        output ihit, imemload, redirect, redirect_addr, deq_ready
    );
endinterface

// File: rtl/fetch_queue.sv
// Fetch PC generator with a DEPTH-entry {pc, instr} queue decoupling the icache from decode.
// Redirects flush the queue and restart fetch; an enqueued halt word suspends fetching.
module fetch_queue #(
    parameter int          DEPTH     = 4,
    parameter logic [31:0] PC_INIT   = 32'h0,
    parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
    input  logic CLK,
    input  logic RST,
    fetch_queue_if.master bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [31:0]      r_pc;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             r_fetch_stopped;
    logic [31:0]      r_mem_pc    [DEPTH];
    logic [31:0]      r_mem_instr [DEPTH];

    logic w_full;
    logic w_ren;
    logic w_push;
    logic w_pop;

    assign w_full = (r_count == CNT_W'(DEPTH));
    assign w_ren  = !w_full && !r_fetch_stopped;
    // Redirect squashes both ends: the returning word is wrong-path and the queue is being flushed.
    assign w_push = bus.ihit && w_ren && !bus.redirect;
    assign w_pop  = bus.deq_ready && (r_count != '0) && !bus.redirect;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_pc            <= PC_INIT;
            r_wr_ptr        <= '0;
            r_rd_ptr        <= '0;
            r_count         <= '0;
            r_fetch_stopped <= 1'b0;
        end else if (bus.redirect) begin
            r_pc            <= bus.redirect_addr;
            r_wr_ptr        <= '0;
            r_rd_ptr        <= '0;
            r_count         <= '0;
            r_fetch_stopped <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
                r_pc     <= r_pc + 32'd4;
                if (bus.imemload == HALT_WORD) begin
                    r_fetch_stopped <= 1'b1;
                end
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage is not reset; occupancy alone decides which slots are meaningful.
    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_mem_pc[r_wr_ptr]    <= r_pc;
            r_mem_instr[r_wr_ptr] <= bus.imemload;
        end
    end

    assign bus.imemREN       = w_ren;
    assign bus.imemaddr      = r_pc;
    assign bus.deq_valid     = (r_count != '0);
    assign bus.deq_pc        = r_mem_pc[r_rd_ptr];
    assign bus.deq_instr     = r_mem_instr[r_rd_ptr];
    assign bus.count         = r_count;
    assign bus.fetch_stopped = r_fetch_stopped;
endmodule
